// File: rtl/iob_cache_be_mem_model.sv
// iob_cache_be_mem_model: byte-enabled, word-organised back-end memory with
//   programmable access latency and read/write completion counters.
// Latency: ack is LATENCY cycles after the capture edge; access period is LATENCY+1.
// Backpressure: a request is held by the master until ack; a new request is
//   only accepted in IDLE, and req seen during WAIT/ACK is ignored.
// Ports: clk_i clock; rst_ni async active-low reset; req_i/addr_i/wdata_i/wstrb_i
//   request (wstrb_i==0 is a read); rdata_o read data (held until next read ack);
//   ack_o one-cycle completion; busy_o transaction in flight; nrd_o/nwr_o counts.
// Optional feature: define IOB_CACHE_BE_MEM_RAND_LAT_EN to add a pseudo-random
//   0..7 extra cycles of latency per access from an 8-bit LFSR.
module iob_cache_be_mem_model #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 24,
  parameter int MEM_ADDR_W = 10,
  parameter int LATENCY    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  ack_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      nrd_o,
  output logic [CNT_W-1:0]      nwr_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int NB_W   = (NBYTES > 1) ? $clog2(NBYTES) : 0;

  // One extra counter bit when random latency is enabled so LATENCY+7 fits.
`ifdef IOB_CACHE_BE_MEM_RAND_LAT_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif

  localparam logic [LW-1:0] LAT_M1 = LW'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  state_t                  state_q;
  logic [LW-1:0]           cnt_q;
  logic [MEM_ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [NBYTES-1:0]       wstrb_q;
  logic                    ack_q;
  logic [DATA_W-1:0]       rdata_q;
  logic [CNT_W-1:0]        nrd_q;
  logic [CNT_W-1:0]        nwr_q;

  // Storage is deliberately not reset: contents survive a reset pulse.
  logic [DATA_W-1:0]       mem_q [2**MEM_ADDR_W];

  // Word index: low byte-offset bits and bits above the memory depth are
  // dropped, so addresses alias modulo the memory size.
  logic [MEM_ADDR_W-1:0]   req_idx;
  logic                    unused_addr;
  assign req_idx     = addr_i[NB_W +: MEM_ADDR_W];
  assign unused_addr = ^addr_i;

  // Latency minus one as loaded into the counter at capture.
  logic [LW-1:0]           lat_m1;

`ifdef IOB_CACHE_BE_MEM_RAND_LAT_EN
  // x^8+x^6+x^5+x^4+1, free-running; low 3 bits pick the extra latency.
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lat_m1 = LAT_M1 + {{(LW-3){1'b0}}, lfsr_q[2:0]};
`else
  assign lat_m1 = LAT_M1;
`endif

  // Commit happens on the edge entering ACK. With a one-cycle latency that
  // edge is also the capture edge, so the live inputs are used instead of
  // the (not yet loaded) capture registers.
  logic                    enter_ack;
  logic [MEM_ADDR_W-1:0]   c_idx;
  logic [DATA_W-1:0]       c_wdata;
  logic [NBYTES-1:0]       c_wstrb;

  always_comb begin
    enter_ack = 1'b0;
    c_idx     = idx_q;
    c_wdata   = wdata_q;
    c_wstrb   = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        enter_ack = req_i && (lat_m1 == '0);
        c_idx     = req_idx;
        c_wdata   = wdata_i;
        c_wstrb   = wstrb_i;
      end
      ST_WAIT: begin
        enter_ack = (cnt_q == LW'(1));
      end
      default: begin
        enter_ack = 1'b0;
      end
    endcase
  end

  // Byte-enabled write port. Gated with rst_ni because this block has no
  // reset of its own and must not commit while reset is held.
  always_ff @(posedge clk_i) begin
    if (enter_ack && rst_ni) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (c_wstrb[b]) begin
          mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      nrd_q   <= '0;
      nwr_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            idx_q   <= req_idx;
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
            cnt_q   <= lat_m1;
            state_q <= (lat_m1 == '0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Counters advance on leaving ACK; they wrap freely.
          state_q <= ST_IDLE;
          if (wstrb_q == '0) begin
            nrd_q <= nrd_q + CNT_W'(1);
          end else begin
            nwr_q <= nwr_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (enter_ack) begin
        ack_q <= 1'b1;
        // rdata only follows reads; writes leave the last read value.
        if (c_wstrb == '0) begin
          rdata_q <= mem_q[c_idx];
        end
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign nrd_o   = nrd_q;
  assign nwr_o   = nwr_q;

endmodule

// File: doc/iob_cache_be_mem_model.md
Name: iob_cache_be_mem_model

Overview:
- Back-end memory model sitting directly downstream of the cache's native back-end port (be_req/be_addr/be_wdata/be_wstrb/be_rdata/be_ack).
- Replaces the single-cycle RAM in simulation with a word-organised, byte-enabled memory with programmable access latency and access counters.
- Used to stress cache miss/refill and write-through buffer paths under realistic back-end stalls.

Parameters:
- DATA_W, 32, back-end data width in bits; multiple of 8.
- ADDR_W, 24, back-end byte-address width.
- MEM_ADDR_W, 10, log2 of memory depth in words.
- LATENCY, 4, cycles from request capture to ack; legal 1..255.
- CNT_W, 16, width of the read and write access counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  request, level; held with addr/wdata/wstrb stable until ack.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte enables; 0 = read, nonzero = write.
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high while a transaction is in flight (WAIT or ACK).
- nrd  out  CNT_W  completed read count.
- nwr  out  CNT_W  completed write count.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-low.
- Reset values (rst low):
  - state = IDLE.
  - ack = 0, busy = 0, rdata = 0, nrd = 0, nwr = 0, latency counter = 0.
  - Memory contents are not cleared.
- Word index: addr[MEM_ADDR_W+NB_W-1:NB_W], where NB_W = log2(DATA_W/8).
  - Upper address bits are ignored, so addresses alias modulo the memory size.
  - Low NB_W bits are ignored.
- FSM: IDLE, WAIT, ACK.
  - IDLE:
    - If req=1 at the clock edge, capture addr/wdata/wstrb and load cnt = LATENCY-1.
    - Go to ACK if LATENCY=1, otherwise go to WAIT.
  - WAIT:
    - cnt decrements each cycle.
    - When cnt=1 at the edge, go to ACK.
  - Commit on the edge entering ACK:
    - Write: bytes with wstrb[i]=1 are written; other bytes are unchanged.
    - Read: rdata is loaded from mem[index]. rdata is not updated on writes.
  - ACK:
    - ack=1 for exactly this cycle.
    - nrd or nwr increments at the edge leaving ACK.
    - Unconditional transition to IDLE; req sampled during ACK is ignored.
- Latency and throughput:
  - ack is asserted LATENCY cycles after the capture edge.
  - One IDLE bubble between back-to-back transactions, so the access period is LATENCY+1 cycles.
  - With LATENCY=1 this matches the legacy behaviour of ack registered one cycle after req.
- Read-after-write to the same word returns the newly written bytes.
- Counters wrap at 2^CNT_W without saturation.
- Inputs changing while busy (a protocol violation) do not affect the transaction in flight, because they were captured in IDLE.
- Reset asserted mid-transaction:
  - The transaction is aborted and ack never pulses.
  - A write aborted before reaching ACK leaves memory unchanged.
- busy = (state != IDLE).

Optional Feature:
- Macro: IOB_CACHE_BE_MEM_RAND_LAT_EN.
- When defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1) with reset value 8'hA5 advances every cycle.
  - At capture, the effective latency is LATENCY + lfsr[2:0] (range LATENCY..LATENCY+7), loaded into the counter.
  - The counter is widened by 1 bit so that 255+7 does not overflow.
- When undefined: latency is fixed at LATENCY and no LFSR logic exists.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release with req=0 -> ack=0, busy=0, rdata=0, nrd=nwr=0, and they stay so for 20 cycles.
- Latency, LATENCY=4: write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF -> ack high exactly 4 cycles after the capture edge, for 1 cycle; nwr=1. Then read addr=0x10 -> rdata=0xDEADBEEF in the ack cycle; nrd=1.
- Byte enables: write 0x11223344 with wstrb=4'hF, then 0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
- Aliasing/boundary, MEM_ADDR_W=10: write index 1023 (addr=0xFFC), then read addr=0x1FFC -> same data. Low address bits 0xFFE read the same word.
- Back-to-back, LATENCY=1: keep req high for 10 transactions -> ack every 2nd cycle, 5 acks in 10 cycles; nrd increments once per ack.
- Reset mid-operation: issue a write with LATENCY=8 and assert rst at cycle 3 -> ack never pulses, busy=0, nwr=0, and a subsequent read shows the old data. With IOB_CACHE_BE_MEM_RAND_LAT_EN defined, 100 reads all ack within 4..11 cycles (LATENCY=4).
